// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: per-master transaction states and command encoding.
package xbar_pkg;

  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    WAIT   = 2'd1,
    W_ACK  = 2'd2,
    W_DATA = 2'd3
  } req_state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/slave_arbiter_req_tracker.sv
// One master's view of this slave: capture, transaction FSM, latched request and ack pulse.
module req_tracker
  import xbar_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_no,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cmd,
  input  logic [DATA_W-1:0] wdata,
  input  logic              grant,
  input  logic              slave_ack,
  input  logic              data_read,
  output logic [1:0]        stat,
  output logic              owner,
  output logic              wack,
  output logic              ack,
  output logic              slave_sel,
  output logic [ADDR_W-1:0] addr_lat,
  output logic              cmd_lat,
  output logic [DATA_W-1:0] wdata_lat
);

  req_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cmd_q, cmd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              slave_q, slave_d;
  logic              ack_q, ack_d;
  logic              capture;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= NO_REQ;
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      slave_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      slave_q <= slave_d;
      ack_q   <= ack_d;
    end
  end

  // The ack cycle blocks capture so a req still high then is not taken twice.
  assign capture = req && (addr[ADDR_W-1] == s_no) && !ack_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    slave_d = slave_q;
    unique case (state_q)
      NO_REQ: if (capture) begin
        state_d = WAIT;
        addr_d  = addr;
        cmd_d   = cmd;
        wdata_d = wdata;
        slave_d = s_no;
      end
      WAIT:   if (grant) state_d = W_ACK;
      W_ACK:  if (slave_ack) state_d = (cmd_q == CMD_WRITE) ? NO_REQ : W_DATA;
      W_DATA: if (data_read) state_d = NO_REQ;
      default: state_d = NO_REQ;
    endcase
  end

  always_comb begin
    ack_d     = (state_q == W_ACK) && slave_ack;
    stat      = state_q;
    owner     = (state_q == W_ACK) || (state_q == W_DATA);
    wack      = (state_q == W_ACK);
    ack       = ack_q;
    slave_sel = slave_q;
    addr_lat  = addr_q;
    cmd_lat   = cmd_q;
    wdata_lat = wdata_q;
  end

endmodule

// File: rtl/slave_arbiter.sv
// Per-slave request front end: two request trackers, round-robin grant and slave bus mux.
module slave_arbiter
  import xbar_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_no,
  input  logic              master0_req,
  input  logic              master1_req,
  input  logic [ADDR_W-1:0] master0_addr,
  input  logic [ADDR_W-1:0] master1_addr,
  input  logic              master0_cmd,
  input  logic              master1_cmd,
  input  logic [DATA_W-1:0] master0_wdata,
  input  logic [DATA_W-1:0] master1_wdata,
  output logic              master0_ack,
  output logic              master1_ack,
  output logic              slave_req,
  output logic [ADDR_W-1:0] slave_addr,
  output logic              slave_cmd,
  output logic [DATA_W-1:0] slave_wdata,
  input  logic              slave_ack,
  output logic [1:0]        stat0,
  output logic [1:0]        stat1,
  output logic              slave0,
  output logic              slave1,
  input  logic              data_read0,
  input  logic              data_read1
);

  logic              grant0, grant1;
  logic              owner0, owner1, wack0, wack1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              cmd0, cmd1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              last_grant_q, last_grant_d;
  logic              idle, wait0, wait1;

  req_tracker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_trk0 (
    .clk(clk), .rst_n(rst_n), .s_no(s_no), .req(master0_req), .addr(master0_addr),
    .cmd(master0_cmd), .wdata(master0_wdata), .grant(grant0), .slave_ack(slave_ack),
    .data_read(data_read0), .stat(stat0), .owner(owner0), .wack(wack0), .ack(master0_ack),
    .slave_sel(slave0), .addr_lat(addr0), .cmd_lat(cmd0), .wdata_lat(wdata0)
  );

  req_tracker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_trk1 (
    .clk(clk), .rst_n(rst_n), .s_no(s_no), .req(master1_req), .addr(master1_addr),
    .cmd(master1_cmd), .wdata(master1_wdata), .grant(grant1), .slave_ack(slave_ack),
    .data_read(data_read1), .stat(stat1), .owner(owner1), .wack(wack1), .ack(master1_ack),
    .slave_sel(slave1), .addr_lat(addr1), .cmd_lat(cmd1), .wdata_lat(wdata1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

  // Grants look only at registered state, which forces an idle cycle between owners.
  always_comb begin
    idle         = !owner0 && !owner1;
    wait0        = (stat0 == WAIT);
    wait1        = (stat1 == WAIT);
    grant0       = idle && wait0 && (!wait1 || last_grant_q);
    grant1       = idle && wait1 && (!wait0 || !last_grant_q);
    last_grant_d = last_grant_q;
    if (grant0)      last_grant_d = 1'b0;
    else if (grant1) last_grant_d = 1'b1;
  end

  always_comb begin
    slave_req   = wack0 || wack1;
    slave_addr  = '0;
    slave_cmd   = 1'b0;
    slave_wdata = '0;
    if (owner0) begin
      slave_addr  = addr0;
      slave_cmd   = cmd0;
      slave_wdata = wdata0;
    end else if (owner1) begin
      slave_addr  = addr1;
      slave_cmd   = cmd1;
      slave_wdata = wdata1;
    end
  end

endmodule

// File: tb/tb_slave_arbiter.sv
// Directed bench for slave_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_slave_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_no;
  logic        master0_req, master1_req;
  logic [31:0] master0_addr, master1_addr;
  logic        master0_cmd, master1_cmd;
  logic [31:0] master0_wdata, master1_wdata;
  logic        master0_ack, master1_ack;
  logic        slave_req;
  logic [31:0] slave_addr;
  logic        slave_cmd;
  logic [31:0] slave_wdata;
  logic        slave_ack;
  logic [1:0]  stat0, stat1;
  logic        slave0, slave1;
  logic        data_read0, data_read1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slave_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_no(s_no),
    .master0_req(master0_req), .master1_req(master1_req),
    .master0_addr(master0_addr), .master1_addr(master1_addr),
    .master0_cmd(master0_cmd), .master1_cmd(master1_cmd),
    .master0_wdata(master0_wdata), .master1_wdata(master1_wdata),
    .master0_ack(master0_ack), .master1_ack(master1_ack),
    .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd),
    .slave_wdata(slave_wdata), .slave_ack(slave_ack),
    .stat0(stat0), .stat1(stat1), .slave0(slave0), .slave1(slave1),
    .data_read0(data_read0), .data_read1(data_read1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model (0 idle, 1 queued, 2 on bus, 3 awaiting data) ----
  int          m_st[2];
  logic [31:0] m_addr[2], m_wd[2];
  logic        m_cmd[2], m_sl[2], m_ack[2];
  int          m_last;

  always @(posedge clk) begin : model
    int owner, g;
    logic rq, cm, dr;
    logic [31:0] ad, wd;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] <= 0; m_addr[i] <= '0; m_wd[i] <= '0;
        m_cmd[i] <= 1'b0; m_sl[i] <= 1'b0; m_ack[i] <= 1'b0;
      end
      m_last <= 1;
    end else begin
      owner = -1;
      for (int i = 0; i < 2; i++) if (m_st[i] >= 2) owner = i;
      g = -1;
      if (owner < 0) begin
        if (m_st[0] == 1 && m_st[1] == 1) g = 1 - m_last;
        else if (m_st[0] == 1) g = 0;
        else if (m_st[1] == 1) g = 1;
      end
      if (g >= 0) m_last <= g;
      for (int i = 0; i < 2; i++) begin
        rq = (i == 0) ? master0_req   : master1_req;
        ad = (i == 0) ? master0_addr  : master1_addr;
        cm = (i == 0) ? master0_cmd   : master1_cmd;
        wd = (i == 0) ? master0_wdata : master1_wdata;
        dr = (i == 0) ? data_read0    : data_read1;
        m_ack[i] <= (m_st[i] == 2) && slave_ack;
        case (m_st[i])
          0: if (rq && ad[31] == s_no && !m_ack[i]) begin
            m_st[i] <= 1; m_addr[i] <= ad; m_cmd[i] <= cm; m_wd[i] <= wd; m_sl[i] <= s_no;
          end
          1: if (g == i) m_st[i] <= 2;
          2: if (slave_ack) m_st[i] <= m_cmd[i] ? 0 : 3;
          default: if (dr) m_st[i] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin : compare
    int owner;
    logic [31:0] e_addr, e_wd;
    logic e_cmd;
    owner = -1;
    for (int i = 0; i < 2; i++) if (m_st[i] >= 2) owner = i;
    e_addr = (owner >= 0) ? m_addr[owner] : 32'h0;
    e_wd   = (owner >= 0) ? m_wd[owner]   : 32'h0;
    e_cmd  = (owner >= 0) ? m_cmd[owner]  : 1'b0;
    chk("stat0", {30'd0, stat0}, m_st[0]);
    chk("stat1", {30'd0, stat1}, m_st[1]);
    chk("ack0", {31'd0, master0_ack}, {31'd0, m_ack[0]});
    chk("ack1", {31'd0, master1_ack}, {31'd0, m_ack[1]});
    chk("slave0", {31'd0, slave0}, {31'd0, m_sl[0]});
    chk("slave1", {31'd0, slave1}, {31'd0, m_sl[1]});
    chk("slave_req", {31'd0, slave_req}, {31'd0, (m_st[0] == 2 || m_st[1] == 2)});
    chk("slave_addr", slave_addr, e_addr);
    chk("slave_cmd", {31'd0, slave_cmd}, {31'd0, e_cmd});
    chk("slave_wdata", slave_wdata, e_wd);
    chk("single_owner", {31'd0, (stat0 >= 2'd2 && stat1 >= 2'd2)}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int got[$];
  int exp_order[6] = '{0, 1, 0, 1, 0, 1};
  int found;

  initial begin
    rst_n = 1'b0; s_no = 1'b0;
    master0_req = 1'b1; master1_req = 1'b1;
    master0_addr = 32'h0000_0004; master1_addr = 32'h0000_0008;
    master0_cmd = 1'b1; master1_cmd = 1'b1;
    master0_wdata = 32'h1111_1111; master1_wdata = 32'h2222_2222;
    slave_ack = 1'b0; data_read0 = 1'b0; data_read1 = 1'b0;

    // Reset held with both requests high; master 0 wins the first tie.
    tick(); tick();
    chk("rst_stat0", {30'd0, stat0}, 32'd0);
    chk("rst_stat1", {30'd0, stat1}, 32'd0);
    chk("rst_slave_req", {31'd0, slave_req}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("tie_wait0", {30'd0, stat0}, 32'd1);
    chk("tie_wait1", {30'd0, stat1}, 32'd1);
    tick();
    chk("tie_first_m0", {30'd0, stat0}, 32'd2);
    chk("tie_m1_waits", {30'd0, stat1}, 32'd1);
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0; master0_req = 1'b0;
    chk("tie_ack0", {31'd0, master0_ack}, 32'd1);
    chk("idle_gap", {30'd0, stat1}, 32'd1);
    tick();
    chk("tie_m1_granted", {30'd0, stat1}, 32'd2);
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0; master1_req = 1'b0;
    chk("tie_ack1", {31'd0, master1_ack}, 32'd1);
    tick();

    // Uncontested write by master 0.
    master0_req = 1'b1; master0_addr = 32'h0000_0010; master0_cmd = 1'b1;
    master0_wdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_wait", {30'd0, stat0}, 32'd1);
    tick();
    chk("wr_slave_req", {31'd0, slave_req}, 32'd1);
    chk("wr_slave_addr", slave_addr, 32'h0000_0010);
    chk("wr_slave_wdata", slave_wdata, 32'hDEAD_BEEF);
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0; master0_req = 1'b0;
    chk("wr_ack_pulse", {31'd0, master0_ack}, 32'd1);
    chk("wr_stat_done", {30'd0, stat0}, 32'd0);
    tick();
    chk("wr_ack_low", {31'd0, master0_ack}, 32'd0);

    // Read by master 1, closed by data_read1 four cycles after the ack.
    master1_req = 1'b1; master1_addr = 32'h0000_0020; master1_cmd = 1'b0;
    tick();
    chk("rd_wait", {30'd0, stat1}, 32'd1);
    tick();
    chk("rd_slave_addr", slave_addr, 32'h0000_0020);
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0; master1_req = 1'b0;
    chk("rd_w_data", {30'd0, stat1}, 32'd3);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("rd_hold", {30'd0, stat1}, 32'd3);
      chk("rd_no_slave_req", {31'd0, slave_req}, 32'd0);
    end
    data_read1 = 1'b1;
    tick();
    data_read1 = 1'b0;
    chk("rd_done", {30'd0, stat1}, 32'd0);
    tick();

    // Three contested rounds of writes.
    for (int r = 0; r < 3; r++) begin
      master0_req = 1'b1; master0_addr = 32'h100 + r; master0_cmd = 1'b1; master0_wdata = 32'hA0 + r;
      master1_req = 1'b1; master1_addr = 32'h200 + r; master1_cmd = 1'b1; master1_wdata = 32'hB0 + r;
      tick();
      for (int k = 0; k < 2; k++) begin
        found = -1;
        for (int n = 0; n < 10 && found < 0; n++) begin
          if (stat0 == 2'd2) found = 0;
          else if (stat1 == 2'd2) found = 1;
          else tick();
        end
        if (found < 0) begin
          checks++; failures++;
          $display("FAIL grant_timeout: got no grant expected a grant within 10 cycles");
        end else begin
          got.push_back(found);
          slave_ack = 1'b1;
          tick();
          slave_ack = 1'b0;
          if (found == 0) master0_req = 1'b0; else master1_req = 1'b0;
        end
      end
      tick();
    end
    chk("grant_count", got.size(), 32'd6);
    for (int k = 0; k < 6 && k < got.size(); k++) chk($sformatf("grant_order_%0d", k), got[k], exp_order[k]);

    // Address filter: MSB set while this is slave 0.
    master0_req = 1'b1; master0_addr = 32'h8000_0000; master0_cmd = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("filter_stat0", {30'd0, stat0}, 32'd0);
      chk("filter_slave_req", {31'd0, slave_req}, 32'd0);
    end
    master0_req = 1'b0;
    tick();

    // As slave 1, take a read to W_DATA then reset mid-transaction.
    s_no = 1'b1;
    master0_req = 1'b1; master0_addr = 32'h8000_0040; master0_cmd = 1'b0;
    tick();
    chk("s1_capture", {30'd0, stat0}, 32'd1);
    chk("s1_slave0", {31'd0, slave0}, 32'd1);
    tick();
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0; master0_req = 1'b0;
    chk("s1_w_data", {30'd0, stat0}, 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_stat0", {30'd0, stat0}, 32'd0);
    chk("midrst_slave0", {31'd0, slave0}, 32'd0);
    chk("midrst_ack0", {31'd0, master0_ack}, 32'd0);
    chk("midrst_addr", slave_addr, 32'd0);

    // Stray slave_ack / data_read with no owner.
    slave_ack = 1'b1; data_read0 = 1'b1; data_read1 = 1'b1;
    tick();
    slave_ack = 1'b0; data_read0 = 1'b0; data_read1 = 1'b0;
    chk("stray_stat0", {30'd0, stat0}, 32'd0);
    chk("stray_stat1", {30'd0, stat1}, 32'd0);
    chk("stray_ack0", {31'd0, master0_ack}, 32'd0);
    chk("stray_ack1", {31'd0, master1_ack}, 32'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
